// File: rtl/mult_seq_core.sv
// rtl/mult_seq_core.sv - sequential 16x16 unsigned shift-add multiplier core; optional MULT_EARLY_EXIT_EN build ends RUN once the multiplier is exhausted
module mult_seq_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic [15:0] op_A,
    input  logic [15:0] op_B,
    output logic        done,
    output logic        busy,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] acc;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [4:0]  cnt;

    logic [31:0] acc_sum;
    logic [15:0] mplier_shr;
    logic        run_last;

    // One shift-add step and the decision whether this RUN edge is the last one
    always_comb begin
        acc_sum    = mplier[0] ? (acc + mcand) : acc;
        mplier_shr = mplier >> 1;
`ifdef MULT_EARLY_EXIT_EN
        run_last   = (cnt == 5'd15) || (mplier_shr == 16'd0);
`else
        run_last   = (cnt == 5'd15);
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; init restarts from any state, a new request always wins over completion
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (init) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = init ? S_LOAD : S_RUN;
            end
            S_RUN: begin
                if (init) begin
                    state_next = S_LOAD;
                end else if (run_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (init) begin
                    state_next = S_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands in LOAD, iterate in RUN, publish the product on the final RUN edge
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 16'd0;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    mcand  <= {16'b0, op_A};
                    mplier <= op_B;
                    acc    <= 32'd0;
                    cnt    <= 5'd0;
                end
                S_RUN: begin
                    // An aborting init leaves the partial sum alone; LOAD reinitialises it next cycle
                    if (!init) begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier_shr;
                        cnt    <= cnt + 5'd1;
                        if (run_last) begin
                            result <= acc_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are pure decodes of the state, so they can never overlap
    always_comb begin
        done = (state == S_DONE);
        busy = (state == S_LOAD) || (state == S_RUN);
    end

endmodule

// File: tb/tb_mult_seq_core.sv
// tb/tb_mult_seq_core.sv - table-driven self-checking bench for mult_seq_core
module tb_mult_seq_core;

    logic        clk;
    logic        reset;
    logic        init;
    logic [15:0] op_A;
    logic [15:0] op_B;
    logic        done;
    logic        busy;
    logic [31:0] result;

    int          checks;
    int          failures;
    logic [31:0] model_result;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          lat_full;
        int          lat_early;
        string       name;
    } vec_t;

    vec_t vecs [7];

    mult_seq_core dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .op_A   (op_A),
        .op_B   (op_B),
        .done   (done),
        .busy   (busy),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef MULT_EARLY_EXIT_EN
        return lat_early;
`else
        return lat_full;
`endif
    endfunction

    // init sampled at E0 with wrong operands; real operands appear only for E1, then are scrambled
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] prod,
                          input int lat, input string name);
        int   n;
        int   busy_cnt;
        logic hold_ok;
        init = 1'b1;
        op_A = ~a;
        op_B = ~b;
        step();
        init = 1'b0;
        op_A = a;
        op_B = b;
        check({name, "_done_clr"}, {31'b0, done}, 32'd0);
        n        = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (result !== model_result) hold_ok = 1'b0;
            step();
            n++;
            if (n == 1) begin
                op_A = 16'($urandom);
                op_B = 16'($urandom);
            end
        end
        check({name, "_latency"}, n, lat);
        check({name, "_result"}, result, prod);
        check({name, "_busy_cycles"}, busy_cnt, lat);
        check({name, "_old_result_held"}, {31'b0, hold_ok}, 32'd1);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        model_result = prod;
        repeat (3) step();
        check({name, "_done_sticky"}, {31'b0, done}, 32'd1);
        check({name, "_result_sticky"}, result, prod);
    endtask

    initial begin
        int   n;
        logic saw_done;
        logic held_ok;

        checks       = 0;
        failures     = 0;
        model_result = 32'd0;

        vecs[0] = '{16'h1234, 16'h0000, 32'h0000_0000, 17,  2, "zero_b"};
        vecs[1] = '{16'h0003, 16'h0005, 32'h0000_000F, 17,  4, "3x5"};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 17, "max_max"};
        vecs[3] = '{16'h0100, 16'h0100, 32'h0001_0000, 17, 10, "b2b_0100"};
        vecs[4] = '{16'h00FF, 16'h8001, 32'h007F_80FF, 17, 17, "ff_x_8001"};
        vecs[5] = '{16'hABCD, 16'h0001, 32'h0000_ABCD, 17,  2, "one_b"};
        vecs[6] = '{16'h1234, 16'h5678, 32'h0626_0060, 17, 16, "1234x5678"};

        reset = 1'b1;
        init  = 1'b0;
        op_A  = 16'd0;
        op_B  = 16'd0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", result, 32'd0);

        // reset in the middle of RUN
        init = 1'b1;
        op_A = 16'd3;
        op_B = 16'd5;
        step();
        init = 1'b0;
        step();
        step();
        check("midrun_busy_before_reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        init  = 1'b1;
        step();
        reset = 1'b0;
        init  = 1'b0;
        check("midrun_reset_busy", {31'b0, busy}, 32'd0);
        check("midrun_reset_done", {31'b0, done}, 32'd0);
        check("midrun_reset_result", result, 32'd0);
        saw_done = 1'b0;
        repeat (20) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        check("midrun_reset_stays_idle", {31'b0, saw_done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod,
                   pick_lat(vecs[i].lat_full, vecs[i].lat_early), vecs[i].name);
        end

        // abort: op_A written at E0, op_B written with a second init at E5
        init = 1'b1;
        op_A = 16'd7;
        op_B = 16'hFFFF;
        step();
        init     = 1'b0;
        saw_done = 1'b0;
        held_ok  = 1'b1;
        repeat (4) begin
            step();
            if (done) saw_done = 1'b1;
            if (result !== model_result) held_ok = 1'b0;
        end
        init = 1'b1;
        op_B = 16'd6;
        step();
        init = 1'b0;
        n    = 0;
        while (!done && n < 40) begin
            if (result !== model_result) held_ok = 1'b0;
            step();
            n++;
        end
        check("abort_latency", n, pick_lat(17, 4));
        check("abort_result", result, 32'h0000_002A);
        check("abort_no_early_done", {31'b0, saw_done}, 32'd0);
        check("abort_result_held", {31'b0, held_ok}, 32'd1);
        model_result = 32'h0000_002A;

        // init held high: the core keeps reloading and never completes
        init    = 1'b1;
        op_A    = 16'd9;
        op_B    = 16'd9;
        held_ok = 1'b1;
        repeat (24) begin
            step();
            if (done || !busy) held_ok = 1'b0;
        end
        check("init_held_never_done", {31'b0, held_ok}, 32'd1);
        run_op(16'd9, 16'd9, 32'h0000_0051, pick_lat(17, 5), "after_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
